// File: rtl/button_debounce_pkg.sv
// Shared constants and helpers for the pushbutton debouncer.
package debounce_pkg;

    localparam int unsigned default_stable_cycles_lp = 120000; // 10 ms at 12 MHz
    localparam int unsigned sim_stable_cycles_lp     = 4;

    // Counter must hold values up to stable_cycles-1; sized from stable_cycles+1.
    function automatic int unsigned cnt_width_f(input int unsigned stable_cycles);
        return (stable_cycles < 1) ? 1 : $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/button_debounce_if.sv
// Button bundle: raw inputs towards the debouncer, clean levels and pulses back.
interface button_debounce_if #(
    parameter int unsigned width_p = 3
);

    logic [width_p-1:0] btn_async_i;
    logic [width_p-1:0] level_o;
    logic [width_p-1:0] press_o;
    logic [width_p-1:0] release_o;

    modport master (
        output btn_async_i,
        input  level_o,
        input  press_o,
        input  release_o
    );

    modport slave (
        input  btn_async_i,
        output level_o,
        output press_o,
        output release_o
    );

endinterface

// File: rtl/button_debounce_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset level.
module sync2 #(
    parameter int unsigned width_p       = 1,
    parameter logic        reset_level_p = 1'b0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] d_i,
    output logic [width_p-1:0] q_o
);

    logic [width_p-1:0] meta_q;
    logic [width_p-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= {width_p{reset_level_p}};
            sync_q <= {width_p{reset_level_p}};
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Per-channel debouncer: synchronize, require a stable run of disagreeing samples,
// then update the clean level and emit a registered one-cycle press/release pulse.
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned width_p         = 3,
    parameter int unsigned stable_cycles_p = default_stable_cycles_lp,
    parameter logic        reset_level_p   = 1'b0
) (
    input logic               clk_i,
    input logic               reset_i,
    button_debounce_if.slave  btn_if
);

    localparam int unsigned            cnt_w_lp    = cnt_width_f(stable_cycles_p);
    localparam logic [cnt_w_lp-1:0]    cnt_last_lp = cnt_w_lp'(stable_cycles_p - 1);
    localparam logic [cnt_w_lp-1:0]    cnt_one_lp  = cnt_w_lp'(1);

    logic [width_p-1:0] sync;
    logic [width_p-1:0] level_w;
    logic [width_p-1:0] press_w;
    logic [width_p-1:0] release_w;

    sync2 #(
        .width_p      (width_p),
        .reset_level_p(reset_level_p)
    ) u_sync2 (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    (btn_if.btn_async_i),
        .q_o    (sync)
    );

    for (genvar ch = 0; ch < width_p; ch++) begin : g_ch
        logic [cnt_w_lp-1:0] cnt_q, cnt_d;
        logic                level_q, level_d;
        logic                press_q, press_d;
        logic                release_q, release_d;

        // Any agreeing sample restarts the run, so short glitches never accumulate.
        always_comb begin
            cnt_d     = cnt_q;
            level_d   = level_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync[ch] == level_q) begin
                cnt_d = '0;
            end else if (cnt_q == cnt_last_lp) begin
                level_d   = sync[ch];
                cnt_d     = '0;
                press_d   = sync[ch];
                release_d = ~sync[ch];
            end else begin
                cnt_d = cnt_q + cnt_one_lp;
            end
        end

        always_ff @(posedge clk_i) begin
            if (reset_i) begin
                cnt_q     <= '0;
                level_q   <= reset_level_p;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                level_q   <= level_d;
                press_q   <= press_d;
                release_q <= release_d;
            end
        end

        assign level_w[ch]   = level_q;
        assign press_w[ch]   = press_q;
        assign release_w[ch] = release_q;
    end

    assign btn_if.level_o   = level_w;
    assign btn_if.press_o   = press_w;
    assign btn_if.release_o = release_w;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios with literal expectations plus
// randomized bouncing, all compared every cycle against a run-length reference model.
module tb_button_debounce;
    import debounce_pkg::*;

    localparam int unsigned W      = 3;
    localparam int unsigned STABLE = sim_stable_cycles_lp;
    localparam logic        RL     = 1'b0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    button_debounce_if #(.width_p(W)) bif ();

    button_debounce #(
        .width_p        (W),
        .stable_cycles_p(STABLE),
        .reset_level_p  (RL)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .btn_if (bif)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: input passes through two sample stages; a channel accepts
    // when the last STABLE synchronized samples all disagree with its level.
    logic [W-1:0] m_s1  = '0;
    logic [W-1:0] m_s2  = '0;
    logic [W-1:0] m_lvl = '0;
    logic [W-1:0] m_prs = '0;
    logic [W-1:0] m_rel = '0;
    logic [W-1:0] hist[$];

    always @(posedge clk) begin
        if (rst) begin
            m_s1  = {W{RL}};
            m_s2  = {W{RL}};
            m_lvl = {W{RL}};
            m_prs = '0;
            m_rel = '0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > STABLE) void'(hist.pop_front());
            m_prs = '0;
            m_rel = '0;
            for (int c = 0; c < W; c++) begin
                int run;
                run = 0;
                for (int k = hist.size() - 1; k >= 0; k--) begin
                    if (hist[k][c] != m_lvl[c]) run++;
                    else break;
                end
                if (run >= STABLE) begin
                    if (m_s2[c]) m_prs[c] = 1'b1;
                    else         m_rel[c] = 1'b1;
                    m_lvl[c] = m_s2[c];
                end
            end
            m_s2 = m_s1;
            m_s1 = bif.btn_async_i;
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [W-1:0] b, input logic r);
        bif.btn_async_i = b;
        rst             = r;
        @(posedge clk);
        #1;
        chk("model_level",   bif.level_o,   m_lvl);
        chk("model_press",   bif.press_o,   m_prs);
        chk("model_release", bif.release_o, m_rel);
    endtask

    task automatic lit(input string name, input logic [W-1:0] lvl,
                       input logic [W-1:0] prs, input logic [W-1:0] rel);
        chk({name, "_level"},   bif.level_o,   lvl);
        chk({name, "_press"},   bif.press_o,   prs);
        chk({name, "_release"}, bif.release_o, rel);
    endtask

    initial begin
        logic [W-1:0] b;
        bif.btn_async_i = '0;

        // Reset held with all buttons pressed, then acceptance 5 edges after release
        tick(3'b111, 1'b1); lit("rst0", 3'b000, 3'b000, 3'b000);
        tick(3'b111, 1'b1); lit("rst1", 3'b000, 3'b000, 3'b000);
        repeat (5) tick(3'b111, 1'b0);
        lit("rst_pre", 3'b000, 3'b000, 3'b000);
        tick(3'b111, 1'b0); lit("rst_acc",  3'b111, 3'b111, 3'b000);
        tick(3'b111, 1'b0); lit("rst_post", 3'b111, 3'b000, 3'b000);
        repeat (8) tick(3'b000, 1'b0);
        lit("idle", 3'b000, 3'b000, 3'b000);

        // Clean press and release on channel 0
        repeat (5) tick(3'b001, 1'b0);
        lit("c0_pre", 3'b000, 3'b000, 3'b000);
        tick(3'b001, 1'b0); lit("c0_acc",  3'b001, 3'b001, 3'b000);
        tick(3'b001, 1'b0); lit("c0_post", 3'b001, 3'b000, 3'b000);
        repeat (5) tick(3'b000, 1'b0);
        lit("c0_rpre", 3'b001, 3'b000, 3'b000);
        tick(3'b000, 1'b0); lit("c0_rel", 3'b000, 3'b000, 3'b001);
        repeat (3) tick(3'b000, 1'b0);

        // Glitch of 3 cycles is rejected; 4 cycles is accepted
        for (int i = 0; i < 9; i++) begin
            tick((i < 3) ? 3'b010 : 3'b000, 1'b0);
            lit("glitch", 3'b000, 3'b000, 3'b000);
        end
        repeat (4) tick(3'b010, 1'b0);
        tick(3'b000, 1'b0); lit("gl4_pre", 3'b000, 3'b000, 3'b000);
        tick(3'b000, 1'b0); lit("gl4_acc", 3'b010, 3'b010, 3'b000);
        repeat (8) tick(3'b000, 1'b0);

        // Bounce on channel 2 then hold
        tick(3'b100, 1'b0); tick(3'b000, 1'b0); tick(3'b100, 1'b0); tick(3'b000, 1'b0);
        tick(3'b100, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(3'b100, 1'b0);
            lit("bnc_pre", 3'b000, 3'b000, 3'b000);
        end
        tick(3'b100, 1'b0); lit("bnc_acc", 3'b100, 3'b100, 3'b000);
        for (int i = 0; i < 3; i++) begin
            tick(3'b100, 1'b0);
            lit("bnc_hold", 3'b100, 3'b000, 3'b000);
        end
        repeat (8) tick(3'b000, 1'b0);

        // Reset in the middle of a count restarts the whole latency
        repeat (3) tick(3'b001, 1'b0);
        tick(3'b001, 1'b1); lit("mr_rst", 3'b000, 3'b000, 3'b000);
        for (int i = 0; i < 5; i++) begin
            tick(3'b001, 1'b0);
            lit("mr_wait", 3'b000, 3'b000, 3'b000);
        end
        tick(3'b001, 1'b0); lit("mr_acc", 3'b001, 3'b001, 3'b000);
        repeat (8) tick(3'b000, 1'b0);

        // Simultaneous press on ch0 and release on ch1
        repeat (6) tick(3'b010, 1'b0);
        lit("sim_pre", 3'b010, 3'b010, 3'b000);
        repeat (5) tick(3'b001, 1'b0);
        lit("sim_wait", 3'b010, 3'b000, 3'b000);
        tick(3'b001, 1'b0); lit("sim_acc", 3'b001, 3'b001, 3'b010);
        repeat (8) tick(3'b000, 1'b0);

        // Randomized bouncing with occasional resets
        b = '0;
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < W; c++)
                if ($urandom_range(0, 4) == 0) b[c] = ~b[c];
            tick(b, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
